uart_core: RTL
==============

# uart_core

Synthesizable full-duplex UART core: parametrised data width, optional parity, 1 or 2 stop bits, with 16x oversampling and majority-vote bit sampling on receive. Sits between the FPGA pins (rx/tx) and user logic on the Spartan-3 designs. Exposes a valid/ready byte interface on the transmit side and a one-cycle strobe with error flags on the receive side.

## Interface
- FREQ, 50_000_000: system clock frequency in Hz
- BAUDRATE, 115_200: line rate in bit/s
- DATA_BITS, 8: payload bits per frame, legal 5..9
- STOP_BITS, 1: stop bits, legal 1 or 2
- PARITY_ODD, 0: 0 = even parity, 1 = odd; ignored without UART_PARITY_EN
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- rx  in  1  serial input, asynchronous to clk
- tx  out  1  serial output, idle high
- tx_data  in  DATA_BITS  byte to send, LSB first
- tx_valid  in  1  tx_data is valid
- tx_ready  out  1  transmitter idle, accepts tx_data
- rx_data  out  DATA_BITS  last received payload
- rx_valid  out  1  one-cycle strobe, rx_data and error flags valid
- rx_frame_err  out  1  stop bit(s) sampled low; valid with rx_valid
- rx_parity_err  out  1  parity mismatch; valid with rx_valid; constant 0 without UART_PARITY_EN

## Operation
- Oversample divider DIV = FREQ/(BAUDRATE*16), integer, truncated; one tick every DIV clocks; bit = 16 ticks.
- Reset values: tx=1, tx_ready=1, rx_valid=0, rx_data=0, rx_frame_err=0, rx_parity_err=0; both FSMs in IDLE, dividers cleared.
- TX FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
  - Handshake: transfer when tx_valid && tx_ready at rising clk; tx_data captured in shift register; tx_ready falls next cycle.
  - TX divider restarts on transfer; every state holds tx for exactly 16 ticks; DATA shifts DATA_BITS bits LSB first.
  - STOP holds tx=1 for STOP_BITS*16 ticks; tx_ready rises on the cycle after last STOP tick; tx_valid ignored while tx_ready=0.
- RX path: rx passed through 2-flop synchroniser before any use.
- RX FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
  - IDLE: falling edge of synchronised rx restarts RX divider and tick counter.
  - Each bit sampled at ticks 7, 8, 9; bit value = majority of 3.
  - START majority 1 -> false start, back to IDLE, no strobe.
  - DATA shifts DATA_BITS bits LSB first; PARITY compared against XOR of data (inverted if PARITY_ODD).
  - STOP: each stop bit voted; any low -> rx_frame_err=1. After vote of last stop bit (tick 9), FSM returns to IDLE immediately so next start edge is caught within the remaining half bit.
  - rx_valid pulses one cycle on the cycle after last stop vote; rx_data and error flags updated same cycle and held until next strobe.
- Simultaneous events: TX and RX fully independent; rx activity during transmission has no effect on tx.
- Framing error frame still delivers rx_data; break (rx held low) yields one strobe with rx_frame_err=1, then waits for rx high before rearming IDLE edge detect.
- Reset mid-frame: tx forced high asynchronously, partial RX frame discarded, no strobe.

## Timing
- tx falls 1 cycle after transfer cycle (registered output); frame length = (1+DATA_BITS+P+STOP_BITS)*16*DIV clocks, P=1 with parity else 0.
- RX strobe latency from rx falling edge at pin: 2 (sync) + 1 (edge) + ((1+DATA_BITS+P+STOP_BITS-1)*16+9)*DIV + 1 clocks.
- Tolerated baud mismatch: ±3% with 8N1.

## Configuration
- UART_PARITY_EN defined: PARITY state present in both FSMs, parity bit generated after data and checked on receive, PARITY_ODD honoured.
- Not defined: PARITY states removed, frames carry no parity bit, rx_parity_err tied 0.

## Structure
- Package uart_pkg: TX/RX state encodings, tick count constants (16, sample points 7/8/9), function computing DIV from FREQ and BAUDRATE.
- One sub-module uart_baud_tick: DIV counter with synchronous restart input and tick output; instantiated twice (TX, RX).

## Test plan
- 8N1, DIV=27: send tx_data=0x55 -> tx shows 0,1,0,1,0,1,0,1,0,1 each 432 clocks, then high; tx_ready low for 4320 clocks.
- Bench drives 0xA3 serially on rx at 115200 -> one rx_valid strobe, rx_data=0xA3, both error flags 0.
- rx low glitch of 3 ticks, then high -> no rx_valid; next valid frame 0x0F received correctly.
- Stop bit driven low on frame 0x3C -> rx_valid with rx_data=0x3C, rx_frame_err=1.
- UART_PARITY_EN, PARITY_ODD=0: frame 0x07 with parity bit 0 (wrong) -> rx_parity_err=1; with parity bit 1 -> rx_parity_err=0.
- Assert rst mid-transmission of 0xFF -> tx=1 and tx_ready=1 immediately; after release, frame 0x81 sent intact.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types, tick constants and helpers for uart_core.
package uart_pkg;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4
  } rx_state_t;

  localparam int unsigned TICKS_PER_BIT = 16;
  // Sample points are 1-based tick numbers within a bit.
  localparam int unsigned SAMPLE_EARLY  = 7;
  localparam int unsigned SAMPLE_MID    = 8;
  localparam int unsigned SAMPLE_LATE   = 9;

  function automatic int unsigned calc_div(input int unsigned freq, input int unsigned baud);
    int unsigned d;
    d = freq / (baud * 32'd16);
    return (d == 32'd0) ? 32'd1 : d;
  endfunction

  function automatic logic maj3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

  function automatic logic parity_of(input logic [8:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-cycle tick every DIV clocks, restartable.
module uart_baud_tick #(
  parameter int unsigned DIV = 27
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int unsigned W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [W-1:0] cnt_r;

  // Divider counter, cleared by restart so the first tick lands DIV clocks later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (restart || tick) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + {{(W-1){1'b0}}, 1'b1};
    end
  end

  assign tick = (cnt_r == W'(DIV - 1)) && !restart;

endmodule

// File: rtl/uart_core.sv
// Full-duplex UART with 16x oversampled, majority-voted receiver.
// Optional parity bit enabled by defining UART_PARITY_EN.
module uart_core #(
  parameter int unsigned FREQ       = 50_000_000,
  parameter int unsigned BAUDRATE   = 115_200,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic                 tx,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_frame_err,
  output logic                 rx_parity_err
);
  import uart_pkg::*;

  localparam int unsigned DIV = calc_div(FREQ, BAUDRATE);
  localparam logic [3:0] BIT_END   = 4'(TICKS_PER_BIT - 1);
  localparam logic [3:0] VOTE_A    = 4'(SAMPLE_EARLY - 1);
  localparam logic [3:0] VOTE_B    = 4'(SAMPLE_MID - 1);
  localparam logic [3:0] VOTE_C    = 4'(SAMPLE_LATE - 1);
  localparam logic [3:0] DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0] STOP_LAST = 4'(STOP_BITS - 1);

  tx_state_t            tx_state_r;
  logic [DATA_BITS-1:0] tx_shift_r;
  logic [3:0]           tx_tick_cnt_r;
  logic [3:0]           tx_bit_cnt_r;
  logic                 tx_tick_s;

  rx_state_t            rx_state_r;
  logic                 rx_meta_r, rx_sync_r, rx_prev_r;
  logic [1:0]           rx_vote_r;
  logic [DATA_BITS-1:0] rx_shift_r;
  logic [3:0]           rx_tick_cnt_r;
  logic [3:0]           rx_bit_cnt_r;
  logic                 rx_ferr_r;
  logic                 rx_tick_s;
  logic                 rx_fall_s;
  logic                 rx_bit_s;
`ifdef UART_PARITY_EN
  logic                 tx_par_r;
  logic                 rx_perr_r;
`endif

  uart_baud_tick #(.DIV(DIV)) u_tx_tick (
    .clk(clk), .rst(rst), .restart(tx_state_r == TX_IDLE), .tick(tx_tick_s)
  );

  uart_baud_tick #(.DIV(DIV)) u_rx_tick (
    .clk(clk), .rst(rst), .restart(rx_state_r == RX_IDLE), .tick(rx_tick_s)
  );

  // Transmit FSM: every bit is held for 16 ticks, stop bits for STOP_BITS*16.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state_r    <= TX_IDLE;
      tx            <= 1'b1;
      tx_ready      <= 1'b1;
      tx_shift_r    <= '0;
      tx_tick_cnt_r <= 4'd0;
      tx_bit_cnt_r  <= 4'd0;
`ifdef UART_PARITY_EN
      tx_par_r      <= 1'b0;
`endif
    end else begin
      case (tx_state_r)
        TX_IDLE: begin
          if (tx_valid) begin
            tx_state_r    <= TX_START;
            tx            <= 1'b0;
            tx_ready      <= 1'b0;
            tx_shift_r    <= tx_data;
            tx_tick_cnt_r <= 4'd0;
            tx_bit_cnt_r  <= 4'd0;
`ifdef UART_PARITY_EN
            tx_par_r      <= parity_of(9'(tx_data), PARITY_ODD != 0);
`endif
          end
        end
        TX_START, TX_DATA, TX_PARITY, TX_STOP: begin
          if (tx_tick_s) begin
            tx_tick_cnt_r <= tx_tick_cnt_r + 4'd1;
            if (tx_tick_cnt_r == BIT_END) begin
              case (tx_state_r)
                TX_START: begin
                  tx_state_r <= TX_DATA;
                  tx         <= tx_shift_r[0];
                  tx_shift_r <= tx_shift_r >> 1;
                end
                TX_DATA: begin
                  if (tx_bit_cnt_r == DATA_LAST) begin
                    tx_bit_cnt_r <= 4'd0;
`ifdef UART_PARITY_EN
                    tx_state_r   <= TX_PARITY;
                    tx           <= tx_par_r;
`else
                    tx_state_r   <= TX_STOP;
                    tx           <= 1'b1;
`endif
                  end else begin
                    tx_bit_cnt_r <= tx_bit_cnt_r + 4'd1;
                    tx           <= tx_shift_r[0];
                    tx_shift_r   <= tx_shift_r >> 1;
                  end
                end
`ifdef UART_PARITY_EN
                TX_PARITY: begin
                  tx_state_r <= TX_STOP;
                  tx         <= 1'b1;
                end
`endif
                TX_STOP: begin
                  if (tx_bit_cnt_r == STOP_LAST) begin
                    tx_state_r <= TX_IDLE;
                    tx_ready   <= 1'b1;
                  end else begin
                    tx_bit_cnt_r <= tx_bit_cnt_r + 4'd1;
                  end
                end
                default: begin
                  tx_state_r <= TX_IDLE;
                  tx         <= 1'b1;
                  tx_ready   <= 1'b1;
                end
              endcase
            end
          end
        end
        default: begin
          tx_state_r <= TX_IDLE;
          tx         <= 1'b1;
          tx_ready   <= 1'b1;
        end
      endcase
    end
  end

  // Two-flop synchroniser plus one history flop for start-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
      rx_prev_r <= 1'b1;
    end else begin
      rx_meta_r <= rx;
      rx_sync_r <= rx_meta_r;
      rx_prev_r <= rx_sync_r;
    end
  end

  assign rx_fall_s = rx_prev_r & ~rx_sync_r;
  assign rx_bit_s  = maj3({rx_vote_r, rx_sync_r});

  // Receive FSM: votes at the bit centre; the last stop vote ends the frame early
  // so a back-to-back start edge is still caught.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state_r    <= RX_IDLE;
      rx_vote_r     <= 2'b00;
      rx_shift_r    <= '0;
      rx_tick_cnt_r <= 4'd0;
      rx_bit_cnt_r  <= 4'd0;
      rx_ferr_r     <= 1'b0;
      rx_valid      <= 1'b0;
      rx_data       <= '0;
      rx_frame_err  <= 1'b0;
`ifdef UART_PARITY_EN
      rx_perr_r     <= 1'b0;
      rx_parity_err <= 1'b0;
`endif
    end else begin
      rx_valid <= 1'b0;
      case (rx_state_r)
        RX_IDLE: begin
          if (rx_fall_s) begin
            rx_state_r    <= RX_START;
            rx_tick_cnt_r <= 4'd0;
            rx_bit_cnt_r  <= 4'd0;
            rx_ferr_r     <= 1'b0;
`ifdef UART_PARITY_EN
            rx_perr_r     <= 1'b0;
`endif
          end
        end
        RX_START, RX_DATA, RX_PARITY, RX_STOP: begin
          if (rx_tick_s) begin
            rx_tick_cnt_r <= rx_tick_cnt_r + 4'd1;
            if (rx_tick_cnt_r == VOTE_A || rx_tick_cnt_r == VOTE_B) begin
              rx_vote_r <= {rx_vote_r[0], rx_sync_r};
            end
            if (rx_tick_cnt_r == VOTE_C) begin
              case (rx_state_r)
                RX_START: begin
                  if (rx_bit_s) rx_state_r <= RX_IDLE;
                end
                RX_DATA: rx_shift_r <= {rx_bit_s, rx_shift_r[DATA_BITS-1:1]};
`ifdef UART_PARITY_EN
                RX_PARITY: rx_perr_r <= rx_bit_s ^ parity_of(9'(rx_shift_r), PARITY_ODD != 0);
`endif
                RX_STOP: begin
                  if (rx_bit_cnt_r == STOP_LAST) begin
                    rx_state_r    <= RX_IDLE;
                    rx_valid      <= 1'b1;
                    rx_data       <= rx_shift_r;
                    rx_frame_err  <= rx_ferr_r | ~rx_bit_s;
`ifdef UART_PARITY_EN
                    rx_parity_err <= rx_perr_r;
`endif
                  end else begin
                    rx_ferr_r <= rx_ferr_r | ~rx_bit_s;
                  end
                end
                default: rx_state_r <= RX_IDLE;
              endcase
            end
            if (rx_tick_cnt_r == BIT_END) begin
              case (rx_state_r)
                RX_START: rx_state_r <= RX_DATA;
                RX_DATA: begin
                  if (rx_bit_cnt_r == DATA_LAST) begin
                    rx_bit_cnt_r <= 4'd0;
`ifdef UART_PARITY_EN
                    rx_state_r   <= RX_PARITY;
`else
                    rx_state_r   <= RX_STOP;
`endif
                  end else begin
                    rx_bit_cnt_r <= rx_bit_cnt_r + 4'd1;
                  end
                end
                RX_PARITY: rx_state_r <= RX_STOP;
                RX_STOP:   rx_bit_cnt_r <= rx_bit_cnt_r + 4'd1;
                default:   rx_state_r <= RX_IDLE;
              endcase
            end
          end
        end
        default: rx_state_r <= RX_IDLE;
      endcase
    end
  end

`ifndef UART_PARITY_EN
  assign rx_parity_err = 1'b0;
`endif

endmodule
